calc_add_pipe_knl: RTL and testbench



---
 rtl/calc_add_pipe_knl_pkg.sv | 15 +
 rtl/calc_sat_lane.sv | 24 ++
 rtl/calc_add_pipe_knl.sv | 138 +++++++++++++
 tb/tb_calc_add_pipe_knl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_add_pipe_knl_pkg.sv
// Shared definitions for the xkcalc multi-lane add/sub/accumulate kernel.
// Mode encodings follow the adder control front-end; mode 3 behaves as add.
package calc_add_pipe_knl_pkg;

  typedef enum logic [1:0] {
    CalcModeAdd = 2'd0,
    CalcModeSub = 2'd1,
    CalcModeAcc = 2'd2,
    CalcModeAlt = 2'd3
  } calc_mode_e;

  localparam int unsigned DefDataWd  = 16;
  localparam int unsigned DefLaneNum = 4;

endpackage

// File: rtl/calc_sat_lane.sv
// One lane's result stage: takes an exact DATA_WD+1-bit signed value, reports whether it
// leaves the DATA_WD range, and either clamps it or wraps it to DATA_WD bits.
module calc_sat_lane #(
  parameter int unsigned DATA_WD = 16
) (
  input  logic [DATA_WD:0]   sum,
  input  logic               sat,
  output logic [DATA_WD-1:0] res,
  output logic               ovf
);

  localparam logic [DATA_WD-1:0] DataMax = {1'b0, {(DATA_WD-1){1'b1}}};
  localparam logic [DATA_WD-1:0] DataMin = {1'b1, {(DATA_WD-1){1'b0}}};

  always_comb begin
    // Out of range exactly when the two top bits of the extended value disagree.
    ovf = sum[DATA_WD] ^ sum[DATA_WD-1];
    res = sum[DATA_WD-1:0];
    if (ovf && sat) begin
      res = sum[DATA_WD] ? DataMin : DataMax;
    end
  end

endmodule

// File: rtl/calc_add_pipe_knl.sv
// Multi-lane add/sub/accumulate kernel: S1 holds exact per-lane sums, S2 clamps or wraps them,
// with a single shared valid/ready handshake and a sticky overflow flag.
module calc_add_pipe_knl
  import calc_add_pipe_knl_pkg::*;
#(
  parameter int unsigned DATA_WD  = DefDataWd,
  parameter int unsigned LANE_NUM = DefLaneNum
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        cfg_flg_saturation_i,
  input  logic [1:0]                  cfg_mode_i,
  input  logic                        clr_i,
  input  logic                        val_i,
  output logic                        rdy_o,
  input  logic                        lst_i,
  input  logic [LANE_NUM*DATA_WD-1:0] dat_a_i,
  input  logic [LANE_NUM*DATA_WD-1:0] dat_b_i,
  output logic                        val_o,
  input  logic                        rdy_i,
  output logic [LANE_NUM*DATA_WD-1:0] dat_o,
  output logic [LANE_NUM-1:0]         ovf_o,
  output logic                        ovf_sticky_o
);

  logic       en;
  logic       acpt;
  logic       s1_val_q;
  logic       s1_sat_q;
  logic       val_q;
  logic       sticky_q;
  calc_mode_e mode;

  assign en    = ~val_q | rdy_i;
  assign rdy_o = en;
  assign acpt  = val_i & en;
  assign mode  = calc_mode_e'(cfg_mode_i);

  for (genvar l = 0; l < LANE_NUM; l++) begin : g_lane
    logic [DATA_WD-1:0] a;
    logic [DATA_WD-1:0] b;
    logic [DATA_WD:0]   sum_d;
    logic [DATA_WD:0]   sum_q;
    logic [DATA_WD-1:0] acc_q;
    logic [DATA_WD-1:0] acc_res;
    logic [DATA_WD-1:0] res;
    logic               ovf;
    logic [DATA_WD-1:0] dat_q;
    logic               ovf_q;

    assign a = dat_a_i[l*DATA_WD +: DATA_WD];
    assign b = dat_b_i[l*DATA_WD +: DATA_WD];

    always_comb begin
      case (mode)
        CalcModeSub: sum_d = {a[DATA_WD-1], a} - {b[DATA_WD-1], b};
        CalcModeAcc: sum_d = {acc_q[DATA_WD-1], acc_q} + {a[DATA_WD-1], a};
        default:     sum_d = {a[DATA_WD-1], a} + {b[DATA_WD-1], b};
      endcase
    end

    // Accumulator feedback clamps through the same lane logic as the output stage.
    calc_sat_lane #(
      .DATA_WD (DATA_WD)
    ) u_acc_sat (
      .sum (sum_d),
      .sat (cfg_flg_saturation_i),
      .res (acc_res),
      .ovf ()
    );

    calc_sat_lane #(
      .DATA_WD (DATA_WD)
    ) u_out_sat (
      .sum (sum_q),
      .sat (s1_sat_q),
      .res (res),
      .ovf (ovf)
    );

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        acc_q <= '0;
      end else if (clr_i) begin
        acc_q <= '0;
      end else if (acpt && mode == CalcModeAcc) begin
        acc_q <= lst_i ? '0 : acc_res;
      end
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        sum_q <= '0;
        dat_q <= '0;
        ovf_q <= 1'b0;
      end else if (en) begin
        if (val_i) begin
          sum_q <= sum_d;
        end
        if (s1_val_q) begin
          dat_q <= res;
          ovf_q <= ovf;
        end
      end
    end

    assign dat_o[l*DATA_WD +: DATA_WD] = dat_q;
    assign ovf_o[l]                    = ovf_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_val_q <= 1'b0;
      s1_sat_q <= 1'b0;
      val_q    <= 1'b0;
    end else if (en) begin
      s1_val_q <= val_i;
      if (val_i) begin
        s1_sat_q <= cfg_flg_saturation_i;
      end
      val_q <= s1_val_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sticky_q <= 1'b0;
    end else if (clr_i) begin
      sticky_q <= 1'b0;
    end else if (val_q && rdy_i && |ovf_o) begin
      sticky_q <= 1'b1;
    end
  end

  assign val_o        = val_q;
  assign ovf_sticky_o = sticky_q;

endmodule

// File: tb/tb_calc_add_pipe_knl.sv
// Scoreboard bench for calc_add_pipe_knl: directed beats push hand-computed results,
// a negedge monitor compares every presented output and tracks the sticky flag.
module tb_calc_add_pipe_knl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cfg_flg_saturation_i;
  logic [1:0]  cfg_mode_i;
  logic        clr_i;
  logic        val_i;
  logic        rdy_o;
  logic        lst_i;
  logic [63:0] dat_a_i;
  logic [63:0] dat_b_i;
  logic        val_o;
  logic        rdy_i;
  logic [63:0] dat_o;
  logic [3:0]  ovf_o;
  logic        ovf_sticky_o;

  calc_add_pipe_knl #(
    .DATA_WD  (16),
    .LANE_NUM (4)
  ) dut (
    .clk                  (clk),
    .rstn                 (rstn),
    .cfg_flg_saturation_i (cfg_flg_saturation_i),
    .cfg_mode_i           (cfg_mode_i),
    .clr_i                (clr_i),
    .val_i                (val_i),
    .rdy_o                (rdy_o),
    .lst_i                (lst_i),
    .dat_a_i              (dat_a_i),
    .dat_b_i              (dat_b_i),
    .val_o                (val_o),
    .rdy_i                (rdy_i),
    .dat_o                (dat_o),
    .ovf_o                (ovf_o),
    .ovf_sticky_o         (ovf_sticky_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] dat;
    logic [3:0]  ovf;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  bit   exp_sticky = 1'b0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [63:0] p4(input logic [15:0] l0, input logic [15:0] l1,
                                     input logic [15:0] l2, input logic [15:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  // Monitor: compare whatever the DUT presents against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (!rstn) begin
      exp_sticky = 1'b0;
    end else begin
      chk(ovf_sticky_o === exp_sticky, "sticky", 64'(ovf_sticky_o), 64'(exp_sticky));
      if (val_o) begin
        if (sb_q.size() == 0) begin
          chk(1'b0, "unexpected_output", dat_o, 64'h0);
        end else begin
          e = sb_q[0];
          chk(dat_o === e.dat, "dat", dat_o, e.dat);
          chk(ovf_o === e.ovf, "ovf", 64'(ovf_o), 64'(e.ovf));
          if (rdy_i) begin
            void'(sb_q.pop_front());
            if (!clr_i && |e.ovf) exp_sticky = 1'b1;
          end
        end
      end
      if (clr_i) exp_sticky = 1'b0;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat has been accepted.
  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [1:0] mode,
                      input bit sat, input bit lst, input bit clr,
                      input logic [63:0] ed, input logic [3:0] eo);
    bit acc;
    int n;
    val_i = 1'b1; dat_a_i = a; dat_b_i = b; cfg_mode_i = mode;
    cfg_flg_saturation_i = sat; lst_i = lst; clr_i = clr;
    sb_q.push_back('{dat: ed, ovf: eo});
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = rdy_o;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk(1'b0, "accept_timeout", 64'(n), 64'd0);
  endtask

  task automatic idle();
    val_i = 1'b0; lst_i = 1'b0; clr_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (sb_q.size() != 0) chk(1'b0, "drain_timeout", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; rdy_i = 1'b1; cfg_flg_saturation_i = 1'b0; cfg_mode_i = 2'd0;
    clr_i = 1'b0; val_i = 1'b0; lst_i = 1'b0; dat_a_i = '0; dat_b_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk(val_o === 1'b0, "rst_val", 64'(val_o), 64'h0);
    chk(dat_o === 64'h0, "rst_dat", dat_o, 64'h0);
    chk(ovf_o === 4'h0, "rst_ovf", 64'(ovf_o), 64'h0);
    chk(ovf_sticky_o === 1'b0, "rst_sticky", 64'(ovf_sticky_o), 64'h0);
    rstn = 1'b1;
    #1;
    chk(rdy_o === 1'b1, "rst_rdy", 64'(rdy_o), 64'h1);
    @(posedge clk);
    #1;

    // Add / sub / alt-add, saturation on and off, lanes independent.
    send(p4(16'h7FFF, 16'h0010, 16'h8000, 16'h1234), p4(16'h0001, 16'h0020, 16'hFFFF, 16'h1111),
         2'd0, 1'b1, 1'b0, 1'b0, p4(16'h7FFF, 16'h0030, 16'h8000, 16'h2345), 4'b0101);
    send(p4(16'h7FFF, 16'h0010, 16'h8000, 16'h1234), p4(16'h0001, 16'h0020, 16'hFFFF, 16'h1111),
         2'd0, 1'b0, 1'b0, 1'b0, p4(16'h8000, 16'h0030, 16'h7FFF, 16'h2345), 4'b0101);
    send(p4(16'h8000, 16'h0005, 16'h0100, 16'h7FFF), p4(16'h0001, 16'h0007, 16'h0040, 16'hFFFF),
         2'd1, 1'b1, 1'b0, 1'b0, p4(16'h8000, 16'hFFFE, 16'h00C0, 16'h7FFF), 4'b1001);
    send(p4(16'd1, 16'd2, 16'd3, 16'd4), p4(16'd10, 16'd20, 16'd30, 16'd40),
         2'd3, 1'b0, 1'b0, 1'b0, p4(16'd11, 16'd22, 16'd33, 16'd44), 4'b0000);
    idle();
    drain();

    // Accumulate burst with wrap; operand b is garbage and must be ignored.
    send(p4(16'h1000, 16'h0001, 16'hFFFF, 16'h0), 64'hDEAD_BEEF_DEAD_BEEF, 2'd2, 1'b0, 1'b0, 1'b0,
         p4(16'h1000, 16'h0001, 16'hFFFF, 16'h0), 4'b0000);
    send(p4(16'h1000, 16'h0001, 16'hFFFF, 16'h0), 64'hDEAD_BEEF_DEAD_BEEF, 2'd2, 1'b0, 1'b0, 1'b0,
         p4(16'h2000, 16'h0002, 16'hFFFE, 16'h0), 4'b0000);
    send(p4(16'h1000, 16'h0001, 16'hFFFF, 16'h0), 64'hDEAD_BEEF_DEAD_BEEF, 2'd2, 1'b0, 1'b0, 1'b0,
         p4(16'h3000, 16'h0003, 16'hFFFD, 16'h0), 4'b0000);
    send(p4(16'h1000, 16'h0001, 16'hFFFF, 16'h0), 64'hDEAD_BEEF_DEAD_BEEF, 2'd2, 1'b0, 1'b1, 1'b0,
         p4(16'h4000, 16'h0004, 16'hFFFC, 16'h0), 4'b0000);
    send(p4(16'h1, 16'h1, 16'h1, 16'h1), 64'h0, 2'd2, 1'b0, 1'b1, 1'b0,
         p4(16'h1, 16'h1, 16'h1, 16'h1), 4'b0000);

    // Saturating accumulate.
    send(p4(16'h4000, 16'hC000, 16'h7FFF, 16'h0), 64'h0, 2'd2, 1'b1, 1'b0, 1'b0,
         p4(16'h4000, 16'hC000, 16'h7FFF, 16'h0), 4'b0000);
    send(p4(16'h4000, 16'hC000, 16'h7FFF, 16'h0), 64'h0, 2'd2, 1'b1, 1'b0, 1'b0,
         p4(16'h7FFF, 16'h8000, 16'h7FFF, 16'h0), 4'b0101);
    send(p4(16'h4000, 16'hC000, 16'h7FFF, 16'h0), 64'h0, 2'd2, 1'b1, 1'b1, 1'b0,
         p4(16'h7FFF, 16'h8000, 16'h7FFF, 16'h0), 4'b0111);
    idle();
    drain();

    // clr_i together with an accepted accumulate beat.
    send(p4(16'h0100, 16'h0100, 16'h0100, 16'h0100), 64'h0, 2'd2, 1'b0, 1'b0, 1'b0,
         p4(16'h0100, 16'h0100, 16'h0100, 16'h0100), 4'b0000);
    send(p4(16'h0001, 16'h0001, 16'h0001, 16'h0001), 64'h0, 2'd2, 1'b0, 1'b0, 1'b1,
         p4(16'h0101, 16'h0101, 16'h0101, 16'h0101), 4'b0000);
    send(p4(16'h0002, 16'h0002, 16'h0002, 16'h0002), 64'h0, 2'd2, 1'b0, 1'b1, 1'b0,
         p4(16'h0002, 16'h0002, 16'h0002, 16'h0002), 4'b0000);
    idle();
    drain();
    chk(ovf_sticky_o === 1'b0, "sticky_after_clr", 64'(ovf_sticky_o), 64'h0);

    // Backpressure: rdy_i low for 3 cycles in the middle of an 8-beat stream.
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic [63:0] a;
          logic [63:0] e;
          for (int l = 0; l < 4; l++) begin
            a[l*16 +: 16] = 16'(i * 16 + l);
            e[l*16 +: 16] = 16'(i * 16 + l + 256);
          end
          send(a, p4(16'h0100, 16'h0100, 16'h0100, 16'h0100), 2'd0, 1'b0, 1'b0, 1'b0, e, 4'b0000);
        end
        idle();
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        rdy_i = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk(rdy_o === 1'b0, "stall_rdy", 64'(rdy_o), 64'h0);
          @(posedge clk);
          #1;
        end
        rdy_i = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with two beats in flight.
    send(p4(16'h1111, 16'h2222, 16'h3333, 16'h4444), 64'h0, 2'd0, 1'b0, 1'b0, 1'b0, 64'h0, 4'h0);
    send(p4(16'h5555, 16'h6666, 16'h7777, 16'h0888), 64'h0, 2'd0, 1'b0, 1'b0, 1'b0, 64'h0, 4'h0);
    idle();
    #1;
    rstn = 1'b0;
    #1;
    sb_q.delete();
    chk(val_o === 1'b0, "arst_val", 64'(val_o), 64'h0);
    chk(dat_o === 64'h0, "arst_dat", dat_o, 64'h0);
    chk(ovf_o === 4'h0, "arst_ovf", 64'(ovf_o), 64'h0);
    repeat (2) @(negedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk(rdy_o === 1'b1, "post_rst_rdy", 64'(rdy_o), 64'h1);
    send(p4(16'd5, 16'd6, 16'd7, 16'd8), p4(16'd1, 16'd1, 16'd1, 16'd1), 2'd0, 1'b0, 1'b0, 1'b0,
         p4(16'd6, 16'd7, 16'd8, 16'd9), 4'b0000);
    idle();
    @(negedge clk);
    chk(val_o === 1'b0, "latency_n1", 64'(val_o), 64'h0);
    @(negedge clk);
    chk(val_o === 1'b1, "latency_n2", 64'(val_o), 64'h1);
    drain();

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
